// File: rtl/rx_mac_filter.sv
// RX destination-MAC filter: forwards accepted frames through a one-beat output register, discards the rest.
// Latency 1 cycle; input stalls only on a full, undrained output register, never while discarding.
module rx_mac_filter #(
  parameter int CNT_WIDTH    = 32,
  parameter bit ACCEPT_BCAST = 1'b1
) (
  input  logic                 clk156,
  input  logic                 aresetn,
  input  logic [47:0]          my_mac,
  input  logic                 promisc_en,
  input  logic                 mcast_en,
  input  logic [63:0]          s_axis_tdata,
  input  logic [7:0]           s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [63:0]          m_axis_tdata,
  output logic [7:0]           m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [47:0] dmac;
  logic        runt, accept, fire, load, inc_pass, inc_drop;

  // Byte 0 on the wire is the most significant MAC byte.
  assign dmac = {s_axis_tdata[7:0],   s_axis_tdata[15:8],  s_axis_tdata[23:16],
                 s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};

  assign runt   = s_axis_tlast && (s_axis_tkeep[5:0] != 6'h3f);
  assign accept = !runt && (promisc_en ||
                            (dmac == my_mac) ||
                            (ACCEPT_BCAST && (dmac == 48'hffff_ffff_ffff)) ||
                            (mcast_en && s_axis_tdata[0]));

  assign s_axis_tready = (state == DROP) ? 1'b1 : (~m_axis_tvalid | m_axis_tready);
  assign fire          = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    inc_pass  = 1'b0;
    inc_drop  = 1'b0;
    case (state)
      IDLE: begin
        if (fire) begin
          if (accept) begin
            load     = 1'b1;
            inc_pass = 1'b1;
            if (!s_axis_tlast) state_nxt = PASS;
          end else begin
            inc_drop = 1'b1;
            if (!s_axis_tlast) state_nxt = DROP;
          end
        end
      end
      PASS: begin
        if (fire) begin
          load = 1'b1;
          if (s_axis_tlast) state_nxt = IDLE;
        end
      end
      DROP: begin
        if (fire && s_axis_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A load wins over a drain, so back-to-back beats keep tvalid high.
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tkeep  <= s_axis_tkeep;
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      pass_count <= '0;
      drop_count <= '0;
    end else begin
      if (inc_pass) pass_count <= pass_count + CNT_WIDTH'(1);
      if (inc_drop) drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/rx_mac_filter.md
# rx_mac_filter

Receive-side destination-MAC filter placed directly downstream of the 10G network module's RX AXI4-Stream output (64-bit, clk156 domain) and upstream of the UDP/IP stack. It inspects the destination MAC in the first beat of every frame and then does one of two things: forward the whole frame through a one-beat output register, or silently consume and discard it. It keeps wrapping pass and drop frame counters.

## Interface
Parameters:
- CNT_WIDTH, 32, width of pass_count and drop_count.
- ACCEPT_BCAST, 1, when 1, frames to ff:ff:ff:ff:ff:ff are always accepted.

Ports:
- clk156  in  1  sole clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- my_mac  in  48  station MAC; my_mac[47:40] is the first byte on the wire.
- promisc_en  in  1  accept every non-runt frame.
- mcast_en  in  1  accept frames whose destination I/G bit is set.
- s_axis_tdata  in  64  RX data; byte n = tdata[8n+7:8n], byte 0 first on the wire.
- s_axis_tkeep  in  8  byte enables.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  64  filtered data.
- m_axis_tkeep  out  8  filtered byte enables.
- m_axis_tlast  out  1  filtered last.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- pass_count  out  CNT_WIDTH  frames forwarded, wraps.
- drop_count  out  CNT_WIDTH  frames discarded, wraps.

## Operation
- Destination MAC on the first beat: dmac = {tdata[7:0], tdata[15:8], tdata[23:16], tdata[31:24], tdata[39:32], tdata[47:40]}.
- Runt: the first beat has tlast=1 and tkeep[5:0] != 6'h3f. A runt is always dropped.
- Accept, if not runt, when any of these holds:
  - promisc_en=1
  - dmac == my_mac
  - ACCEPT_BCAST=1 and dmac == 48'hffffffffffff
  - mcast_en=1 and tdata[0]=1
- Only my_mac, promisc_en and mcast_en values present on the accepted first beat are used. Changes to them mid-frame do not affect the current frame.
- FSM states are IDLE, PASS and DROP. A beat is accepted when s_axis_tvalid and s_axis_tready are both 1.
  - IDLE, first beat accepted, accept: load the beat into the output register. Go to PASS, or stay in IDLE if tlast=1. Increment pass_count at the first beat.
  - IDLE, first beat accepted, reject: discard the beat. Go to DROP, or stay in IDLE if tlast=1. Increment drop_count at the first beat.
  - PASS: load every accepted beat into the output register. Return to IDLE on the accepted beat with tlast=1.
  - DROP: discard every accepted beat. Return to IDLE on the accepted beat with tlast=1.
- Output register:
  - m_axis_tvalid is set when a beat is loaded.
  - It is cleared when m_axis_tready=1 and no new beat is loaded in the same cycle.
  - Simultaneous load and drain replaces the contents and keeps tvalid=1.
- s_axis_tready:
  - In DROP, s_axis_tready = 1.
  - Otherwise, s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational).
- Counters increment by 1 and wrap from all-ones to 0. Pass and drop never increment in the same cycle.
- tkeep passes through unmodified. tdata of forwarded beats is bit-exact.

## Timing
- Reset values (asynchronous on aresetn=0):
  - state=IDLE
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0
  - pass_count=0, drop_count=0
  - s_axis_tready=1, since the output register is empty.
- Reset asserted mid-frame: any held beat is lost. The next frame starts in IDLE. The remainder of the interrupted frame arriving after reset is treated as a new frame, because the filter has no way to know it is a continuation.
- Latency: 1 cycle from input acceptance to m_axis_tvalid.
- Throughput: 1 beat per cycle with m_axis_tready held at 1.
- Dropped frames see no backpressure in DROP. Their first beat is subject to the output register's ready in IDLE.
- Back-to-back frames: a tlast beat followed immediately by a new first beat in the next cycle is handled with no bubble.
- Counters update in the cycle after the first-beat acceptance edge.
- Input tdata, tkeep and tlast are ignored when s_axis_tvalid=0.

## Test plan
- my_mac=48'h000A35020304. Send a 3-beat frame with beat0 tdata=64'h0000_04030235_0A00 and m_axis_tready=1.
  - All 3 beats appear one cycle later, unchanged.
  - pass_count=1, drop_count=0.
- Same my_mac. Send a 4-beat frame to 00:0a:35:02:03:05.
  - No m_axis_tvalid.
  - s_axis_tready stays 1 for all beats.
  - drop_count=1.
  - A matching frame sent immediately after passes with no bubble.
- Broadcast frame is passed. Multicast 01:00:5e:00:00:01 is dropped with mcast_en=0 and passed with mcast_en=1. With promisc_en=1, a foreign unicast is passed.
- Single-beat frame with tkeep=8'h0f and tlast=1, under promisc_en=1:
  - The frame is dropped.
  - drop_count increments.
- Random m_axis_tready at 50% over 100 mixed frames:
  - The output equals the reference-model filtered stream.
  - No beat is duplicated or lost.
  - pass_count + drop_count = 100.
- Preload pass_count=2^CNT_WIDTH-1 (CNT_WIDTH=4, 15 frames) and pass one more frame: pass_count wraps to 0.
- Assert aresetn=0 mid PASS frame:
  - All outputs return to their reset values immediately.
  - After release, a new matching frame passes correctly.
